fighter_actor: RTL
==================

Name: fighter_actor

Overview:
Consumer of the 3-bit action code produced by the button-decode FSM. Turns the action stream into character motion and strike events: horizontal position, jump height, crouch and hit pulses. Enforces action durations and an attack cooldown, and feeds the renderer and collision logic downstream.

Parameters:
JUMP_H, 4, peak jump height in steps (1..15); height output is 4 bits.
ATTACK_LEN, 3, cycles a kick or punch stays active (1..15).
COOLDOWN, 2, cycles after an attack ends during which new attacks are ignored (0..15).
X_MAX, 200, saturation limit of pos_x (1..255).

Ports:
clock  in  1  single clock; all state changes on the rising edge
reset  in  1  asynchronous, active-low; low clears all state immediately
z  in  3  action code, sampled every rising edge: 0 Kick, 1 Punch, 2 Jump, 3 Duck, 4 Run, 5-7 invalid
pos_x  out  8  horizontal position, saturates at X_MAX
height  out  4  current jump height
crouch  out  1  high while in DUCK
kick_hit  out  1  high while in KICK
punch_hit  out  1  high while in PUNCH
airborne  out  1  high while in JUMP_UP or JUMP_DOWN
busy  out  1  high in any state other than RUN
act_state  out  3  state encoding: RUN=0, KICK=1, PUNCH=2, JUMP_UP=3, JUMP_DOWN=4, DUCK=5

Behaviour:
- Moore outputs: all outputs decode from registered state, pos_x, height and counters only. An action code present before edge N is visible on the outputs after edge N.
- Reset (reset low, asynchronous): state RUN, pos_x 0, height 0, attack counter 0, cooldown 0. All outputs 0.
- RUN state, per edge:
  - z=Run: pos_x <= min(pos_x+1, X_MAX).
  - z=Kick with cooldown=0: go to KICK, counter <= ATTACK_LEN-1.
  - z=Punch with cooldown=0: go to PUNCH, counter <= ATTACK_LEN-1.
  - z=Kick or Punch with cooldown>0: request ignored; stay in RUN, pos_x holds.
  - z=Jump: go to JUMP_UP, height <= 1.
  - z=Duck: go to DUCK.
  - z=5..7: no-op; pos_x holds, stay in RUN.
- KICK / PUNCH:
  - z ignored; pos_x holds.
  - Counter decrements each edge. At counter=0, go to RUN and set cooldown <= COOLDOWN.
  - Each hit output is high for exactly ATTACK_LEN cycles.
- Cooldown: decrements by 1 every edge while nonzero, in any state, except on the edge that loads it.
  - Result: back-to-back attacks with z held are separated by COOLDOWN+1 low cycles.
- JUMP_UP:
  - height +1 each edge; when height=JUMP_H-1, next height is JUMP_H and state goes to JUMP_DOWN.
  - If JUMP_H=1, entry goes directly to JUMP_DOWN with height 1.
- JUMP_DOWN:
  - height -1 each edge; when height=1, next height is 0 and state goes to RUN.
- Every edge spent in JUMP_UP or JUMP_DOWN increments pos_x (saturating), regardless of z. z is ignored while airborne.
- Airborne duration: 2*JUMP_H-1 cycles, with height sequence 1..JUMP_H..1 then 0.
- DUCK: stay while z=Duck; pos_x holds. On any other z, go to RUN. That code is not acted on this edge and is re-evaluated on the next edge.
- Saturation: pos_x never wraps; it holds at X_MAX.
- Reset mid-action: all state is cleared asynchronously. No pending cooldown or partial jump survives reset.

Test Plan:
- Reset, then z=Run for 5 edges -> pos_x=5, busy=0, act_state=0.
- From pos_x=5, one edge z=Kick then z=Run -> kick_hit=1 for exactly 3 cycles, pos_x stays 5, then increments. With z=Kick held instead: kick_hit pattern is 3 high / 3 low / 3 high.
- From pos_x=0, one edge z=Jump then z=Run -> height sequence 1,2,3,4,3,2,1,0; airborne high 7 cycles; pos_x=7 when height returns to 0, then +1 per edge.
- z=Duck for 4 edges, then z=Punch held -> crouch high 4 cycles. The first Punch edge returns to RUN, the next edge starts PUNCH; punch_hit high 3 cycles.
- z=6 for 10 edges from pos_x=3 -> pos_x stays 3, act_state=0. Then z=Run for 300 edges -> pos_x saturates at 200 and holds.
- Drive reset low asynchronously mid-KICK and mid-jump (height=3) -> all outputs 0 before the next clock edge. After release, z=Kick is accepted on the first edge (cooldown cleared).

Source files
------------

// File: rtl/fighter_actor.sv
// Fighter character actor: turns the decoded 3-bit action stream into motion
// (pos_x, jump height) and timed strike pulses with an attack cooldown.
module fighter_actor #(
  parameter int JUMP_H     = 4,
  parameter int ATTACK_LEN = 3,
  parameter int COOLDOWN   = 2,
  parameter int X_MAX      = 200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] z,
  output logic [7:0] pos_x,
  output logic [3:0] height,
  output logic       crouch,
  output logic       kick_hit,
  output logic       punch_hit,
  output logic       airborne,
  output logic       busy,
  output logic [2:0] act_state
);

  typedef enum logic [2:0] {
    S_RUN   = 3'd0,
    S_KICK  = 3'd1,
    S_PUNCH = 3'd2,
    S_JUP   = 3'd3,
    S_JDOWN = 3'd4,
    S_DUCK  = 3'd5
  } state_t;

  localparam logic [2:0] A_KICK  = 3'd0;
  localparam logic [2:0] A_PUNCH = 3'd1;
  localparam logic [2:0] A_JUMP  = 3'd2;
  localparam logic [2:0] A_DUCK  = 3'd3;
  localparam logic [2:0] A_RUN   = 3'd4;

  localparam logic [7:0] XMAX  = 8'(X_MAX);
  localparam logic [3:0] JH    = 4'(JUMP_H);
  localparam logic [3:0] ALEN1 = 4'(ATTACK_LEN - 1);
  localparam logic [3:0] CD    = 4'(COOLDOWN);

  state_t     state_q;
  logic [7:0] pos_q;
  logic [3:0] height_q;
  logic [3:0] cnt_q;
  logic [3:0] cool_q;
  logic [7:0] pos_inc;

  assign pos_inc = (pos_q >= XMAX) ? pos_q : pos_q + 8'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_RUN;
      pos_q    <= 8'd0;
      height_q <= 4'd0;
      cnt_q    <= 4'd0;
      cool_q   <= 4'd0;
    end else begin
      // Free-running cooldown decay; an attack ending below overrides this load.
      if (cool_q != 4'd0) cool_q <= cool_q - 4'd1;
      case (state_q)
        S_RUN: begin
          case (z)
            A_RUN: pos_q <= pos_inc;
            A_KICK: if (cool_q == 4'd0) begin
              state_q <= S_KICK;
              cnt_q   <= ALEN1;
            end
            A_PUNCH: if (cool_q == 4'd0) begin
              state_q <= S_PUNCH;
              cnt_q   <= ALEN1;
            end
            A_JUMP: begin
              height_q <= 4'd1;
              state_q  <= (JH == 4'd1) ? S_JDOWN : S_JUP;
            end
            A_DUCK: state_q <= S_DUCK;
            default: ;
          endcase
        end
        S_KICK, S_PUNCH: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_RUN;
            cool_q  <= CD;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_JUP: begin
          pos_q    <= pos_inc;
          height_q <= height_q + 4'd1;
          if (height_q == JH - 4'd1) state_q <= S_JDOWN;
        end
        S_JDOWN: begin
          pos_q    <= pos_inc;
          height_q <= height_q - 4'd1;
          if (height_q == 4'd1) state_q <= S_RUN;
        end
        S_DUCK: begin
          // Leaving DUCK consumes the edge; the new code is acted on next edge.
          if (z != A_DUCK) state_q <= S_RUN;
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign pos_x     = pos_q;
  assign height    = height_q;
  assign act_state = state_q;
  assign crouch    = (state_q == S_DUCK);
  assign kick_hit  = (state_q == S_KICK);
  assign punch_hit = (state_q == S_PUNCH);
  assign airborne  = (state_q == S_JUP) || (state_q == S_JDOWN);
  assign busy      = (state_q != S_RUN);

endmodule
